// File: rtl/processor_multisend_if.sv
// Bundle of the run-control and per-channel send/ack signals for processor_multisend.
// The master modport is the transmitter's view; the slave modport is the receiver/controller side.
interface processor_multisend_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16
);
    logic                     start;
    logic [DATA_W-1:0]        seed;
    logic [NUM_CH-1:0]        ack;
    logic [NUM_CH-1:0]        outsend;
    logic [NUM_CH*DATA_W-1:0] outdata;
    logic                     busy;
    logic                     done;
    logic [NUM_CH-1:0]        err;

    modport master (
        input  start, seed, ack,
        output outsend, outdata, busy, done, err
    );

    modport slave (
        output start, seed, ack,
        input  outsend, outdata, busy, done, err
    );
endinterface

// File: rtl/processor_multisend.sv
// N-channel four-phase send/ack transmitter. Each channel sends MSG_COUNT words
// starting at seed+i and stepping by NUM_CH. It retries on ack timeout up to MAX_RETRY
// times and then parks in a sticky error state. Every output is a register.
module processor_multisend #(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 16,
    parameter int MSG_COUNT = 8,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic                   clkCPU,
    input  logic                   rst,
    processor_multisend_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int SW = $clog2(MSG_COUNT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND    = 3'd1;
    localparam logic [2:0] S_RELEASE = 3'd2;
    localparam logic [2:0] S_RETRY   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    logic [NUM_CH-1:0]        busy_next_vec;
    logic [NUM_CH-1:0]        fin_next_vec;
    logic [NUM_CH-1:0]        outsend_vec;
    logic [NUM_CH-1:0]        err_vec;
    logic [NUM_CH*DATA_W-1:0] outdata_vec;
    logic                     busy_reg;
    logic                     done_reg;
    logic                     started_reg;
    logic                     accept;

    // busy_reg mirrors the current channel states, so it gates start with no extra logic
    assign accept = bus.start && !busy_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [2:0]        state_reg, state_next;
            logic [DATA_W-1:0] data_reg, data_next;
            logic [SW-1:0]     sent_reg, sent_next;
            logic [RW-1:0]     retry_reg, retry_next;
            logic [TW-1:0]     timer_reg, timer_next;
            logic              outsend_reg;
            logic              err_reg;

            // Per-channel handshake, timeout/retry and message budget
            always_comb begin
                state_next = state_reg;
                data_next  = data_reg;
                sent_next  = sent_reg;
                retry_next = retry_reg;
                timer_next = timer_reg;
                case (state_reg)
                    S_SEND: begin
                        if (bus.ack[gi]) begin
                            state_next = S_RELEASE;
                        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                            if (retry_reg < RW'(MAX_RETRY)) begin
                                state_next = S_RETRY;
                                retry_next = retry_reg + RW'(1);
                            end else begin
                                state_next = S_ERR;
                            end
                        end else begin
                            timer_next = timer_reg + TW'(1);
                        end
                    end
                    S_RETRY: begin
                        timer_next = '0;
                        state_next = S_SEND;
                    end
                    S_RELEASE: begin
                        if (!bus.ack[gi]) begin
                            sent_next  = sent_reg + SW'(1);
                            retry_next = '0;
                            timer_next = '0;
                            if (sent_next == SW'(MSG_COUNT)) begin
                                state_next = S_DONE;
                            end else begin
                                // data only advances on entry to SEND so outdata holds in DONE
                                state_next = S_SEND;
                                data_next  = data_reg + DATA_W'(NUM_CH);
                            end
                        end
                    end
                    default: begin
                        // IDLE, DONE, ERR: only an accepted start moves the channel
                        if (accept) begin
                            state_next = S_SEND;
                            data_next  = bus.seed + DATA_W'(gi);
                            sent_next  = '0;
                            retry_next = '0;
                            timer_next = '0;
                        end
                    end
                endcase
            end

            // Channel state registers; outsend/err are registered from the next state
            always_ff @(posedge clkCPU) begin
                if (rst) begin
                    state_reg   <= S_IDLE;
                    data_reg    <= '0;
                    sent_reg    <= '0;
                    retry_reg   <= '0;
                    timer_reg   <= '0;
                    outsend_reg <= 1'b0;
                    err_reg     <= 1'b0;
                end else begin
                    state_reg   <= state_next;
                    data_reg    <= data_next;
                    sent_reg    <= sent_next;
                    retry_reg   <= retry_next;
                    timer_reg   <= timer_next;
                    outsend_reg <= (state_next == S_SEND);
                    err_reg     <= (state_next == S_ERR);
                end
            end

            assign busy_next_vec[gi] = (state_next == S_SEND) || (state_next == S_RELEASE) ||
                                       (state_next == S_RETRY);
            assign fin_next_vec[gi]  = (state_next == S_DONE) || (state_next == S_ERR);
            assign outsend_vec[gi]   = outsend_reg;
            assign err_vec[gi]       = err_reg;
            assign outdata_vec[gi*DATA_W +: DATA_W] = data_reg;
        end
    endgenerate

    // Run-level status, registered alongside the channel states
    always_ff @(posedge clkCPU) begin
        if (rst) begin
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            started_reg <= 1'b0;
        end else begin
            busy_reg    <= |busy_next_vec;
            done_reg    <= (started_reg || accept) && (&fin_next_vec);
            started_reg <= started_reg || accept;
        end
    end

    assign bus.outsend = outsend_vec;
    assign bus.outdata = outdata_vec;
    assign bus.err     = err_vec;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
endmodule
